// File: rtl/tex_texel_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tex_texel_fetch
// Texel fetch stage of the texture unit. Accepts one per-lane address bundle
// at a time and issues one 32-bit word read per needed texel slot. It collects
// the read responses in any order and extracts each texel by stride. It then
// presents the completed texel quads to the sampler.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_*                 address bundle in (valid/ready handshake)
//   mem_req_*             word read requests out (valid/ready handshake)
//   mem_rsp_*             read responses in (always accepted, tag = slot)
//   rsp_*                 texel quad bundle out (valid/ready handshake)
//
// Slot numbering is lane*4+corner, and this slot number is also the memory tag.
// ---------------------------------------------------------------------------
module tex_texel_fetch #(
  parameter int NUM_LANES   = 4,
  parameter int REQ_TAGW    = 1,
  parameter int W_ADDR_BITS = 38,
  parameter int BLEND_FRAC  = 8,
  parameter int SLOTW       = $clog2(NUM_LANES*4)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  input  logic [NUM_LANES-1:0]              req_mask,
  input  logic                              req_filter,
  input  logic [1:0]                        req_lgstride,
  input  logic [NUM_LANES*W_ADDR_BITS-1:0]  req_baseaddr,
  input  logic [NUM_LANES*4*32-1:0]         req_addr,
  input  logic [NUM_LANES*2*BLEND_FRAC-1:0] req_blends,
  input  logic [REQ_TAGW-1:0]               req_tag,
  output logic                              req_ready,
  output logic                              mem_req_valid,
  output logic [W_ADDR_BITS-3:0]            mem_req_addr,
  output logic [SLOTW-1:0]                  mem_req_tag,
  input  logic                              mem_req_ready,
  input  logic                              mem_rsp_valid,
  input  logic [31:0]                       mem_rsp_data,
  input  logic [SLOTW-1:0]                  mem_rsp_tag,
  output logic                              rsp_valid,
  output logic [NUM_LANES-1:0]              rsp_mask,
  output logic [NUM_LANES*4*32-1:0]         rsp_texels,
  output logic [NUM_LANES*2*BLEND_FRAC-1:0] rsp_blends,
  output logic [REQ_TAGW-1:0]               rsp_tag,
  input  logic                              rsp_ready
);

  localparam int NSLOTS = NUM_LANES * 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  // State and latched bundle
  logic [1:0]                        r_state;
  logic [NUM_LANES-1:0]              r_mask;
  logic                              r_filter;
  logic [1:0]                        r_lgstride;
  logic [W_ADDR_BITS-1:0]            r_base [NUM_LANES];
  logic [31:0]                       r_addr [NSLOTS];
  logic [NUM_LANES*2*BLEND_FRAC-1:0] r_blends;
  logic [REQ_TAGW-1:0]               r_tag;
  logic [NSLOTS-1:0]                 r_needed;
  logic [NSLOTS-1:0]                 r_issued;
  logic [NSLOTS-1:0]                 r_received;
  logic [31:0]                       r_texel [NSLOTS];

  logic [NSLOTS-1:0]                 w_req_needed;
  logic [NSLOTS-1:0]                 w_pending;
  logic [SLOTW-1:0]                  w_sel;
  logic [W_ADDR_BITS-1:0]            w_sel_full;
  logic                              w_accept;
  logic                              w_issue;
  logic                              w_rsp_hit;
  logic [NSLOTS-1:0]                 w_rsp_set;
  logic [NSLOTS-1:0]                 w_issue_set;
  logic [NSLOTS-1:0]                 w_issued_next;
  logic [NSLOTS-1:0]                 w_received_next;
  logic [1:0]                        w_rsp_off;
  logic [31:0]                       w_rsp_texel;
  logic                              w_unused;

  // Needed slots: active lanes, all four corners only for bilinear.
  genvar gi, gc;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      for (gc = 0; gc < 4; gc++) begin : g_corner
        if (gc == 0) begin : g_c0
          assign w_req_needed[gi*4+gc] = req_mask[gi];
        end else begin : g_cn
          assign w_req_needed[gi*4+gc] = req_mask[gi] & req_filter;
        end
        // Point filter replicates corner 0; inactive lanes read zero.
        assign rsp_texels[(gi*4+gc)*32 +: 32] =
          !r_mask[gi] ? 32'd0 :
          (r_filter ? r_texel[gi*4+gc] : r_texel[gi*4]);
      end
    end
  endgenerate

  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  assign w_pending = r_needed & ~r_issued;

  // Lowest needed-but-not-issued slot. It stays put while the memory stalls,
  // which keeps the request fields stable.
  always_comb begin
    w_sel = '0;
    for (int s = NSLOTS - 1; s >= 0; s--) begin
      if (w_pending[s]) w_sel = SLOTW'(s);
    end
  end

  // Full byte address wraps modulo 2^W_ADDR_BITS.
  assign w_sel_full    = r_base[w_sel[SLOTW-1:2]] + W_ADDR_BITS'(r_addr[w_sel]);
  assign w_unused      = ^w_sel_full[1:0];

  assign mem_req_valid = (r_state == ST_FETCH) && (|w_pending);
  assign mem_req_addr  = w_sel_full[W_ADDR_BITS-1:2];
  assign mem_req_tag   = w_sel;
  assign w_issue       = mem_req_valid && mem_req_ready;
  assign w_issue_set   = w_issue ? (NSLOTS'(1) << w_sel) : '0;

  // Only a response for an issued and still-outstanding slot is accepted.
  // Stray responses (for example, after a reset) fall through harmlessly.
  assign w_rsp_hit = mem_rsp_valid && r_issued[mem_rsp_tag] && !r_received[mem_rsp_tag];
  assign w_rsp_set = w_rsp_hit ? (NSLOTS'(1) << mem_rsp_tag) : '0;

  assign w_issued_next   = w_accept ? '0 : (r_issued | w_issue_set);
  assign w_received_next = w_accept ? '0 : (r_received | w_rsp_set);

  // Only the low two address bits matter for the in-word byte offset.
  assign w_rsp_off = r_base[mem_rsp_tag[SLOTW-1:2]][1:0] + r_addr[mem_rsp_tag][1:0];

  always_comb begin
    w_rsp_texel = mem_rsp_data;
    case (r_lgstride)
      2'd0:    w_rsp_texel = {24'd0, mem_rsp_data[{w_rsp_off, 3'b000} +: 8]};
      2'd1:    w_rsp_texel = {16'd0, mem_rsp_data[{w_rsp_off[1], 4'b0000} +: 16]};
      default: w_rsp_texel = mem_rsp_data;   // stride 2, and 3 treated as 2
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_mask     <= '0;
      r_filter   <= 1'b0;
      r_lgstride <= 2'd0;
      r_blends   <= '0;
      r_tag      <= '0;
      r_needed   <= '0;
      r_issued   <= '0;
      r_received <= '0;
      for (int l = 0; l < NUM_LANES; l++) r_base[l] <= '0;
      for (int s = 0; s < NSLOTS; s++) begin
        r_addr[s]  <= '0;
        r_texel[s] <= '0;
      end
    end else begin
      r_issued   <= w_issued_next;
      r_received <= w_received_next;
      if (w_rsp_hit) r_texel[mem_rsp_tag] <= w_rsp_texel;

      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_mask     <= req_mask;
            r_filter   <= req_filter;
            r_lgstride <= req_lgstride;
            r_blends   <= req_blends;
            r_tag      <= req_tag;
            r_needed   <= w_req_needed;
            for (int l = 0; l < NUM_LANES; l++)
              r_base[l] <= req_baseaddr[l*W_ADDR_BITS +: W_ADDR_BITS];
            for (int s = 0; s < NSLOTS; s++)
              r_addr[s] <= req_addr[s*32 +: 32];
            r_state <= (w_req_needed == '0) ? ST_OUT : ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Counting this cycle's receipt lets the last response lead
          // directly into OUT on the following cycle.
          if (w_received_next == r_needed) r_state <= ST_OUT;
        end
        ST_OUT: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_OUT);
  assign rsp_mask   = r_mask;
  assign rsp_blends = r_blends;
  assign rsp_tag    = r_tag;

endmodule
